// File: rtl/stb_drain_arb.sv
// -----------------------------------------------------------------------------
// stb_drain_arb
// Per-core store-buffer drain scheduler for four SPARC threads. Tracks the
// store-buffer occupancy of each thread, picks round-robin which thread's
// oldest store goes to the PCX request path, raises per-thread stall at full
// and records the first enqueue-on-full as a sticky error.
//
// Ports:
//   clk        core clock
//   rst        synchronous reset, active high
//   st_enq     [3:0] one store enqueued for thread t this cycle
//   thr_flush  [3:0] discard all entries of thread t
//   drain_en   blocks new drain requests when low (never retracts one)
//   pcx_ack    PCX accepted the outstanding request
//   pcx_req    drain request valid
//   pcx_thr    [1:0] thread id of the drain request
//   stall      [3:0] thread t store buffer full
//   stbcnt0..3 [CNTW-1:0] per-thread occupancy
//   ovfl_err   sticky overflow flag
//   ovfl_thr   [1:0] thread of the first overflow
// -----------------------------------------------------------------------------
module stb_drain_arb #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      st_enq,
  input  logic [3:0]      thr_flush,
  input  logic            drain_en,
  input  logic            pcx_ack,
  output logic            pcx_req,
  output logic [1:0]      pcx_thr,
  output logic [3:0]      stall,
  output logic [CNTW-1:0] stbcnt0,
  output logic [CNTW-1:0] stbcnt1,
  output logic [CNTW-1:0] stbcnt2,
  output logic [CNTW-1:0] stbcnt3,
  output logic            ovfl_err,
  output logic [1:0]      ovfl_thr
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      pcx_thr_q, pcx_thr_d;
  logic [CNTW-1:0] cnt_q [4];
  logic [CNTW-1:0] cnt_d [4];
  logic            ovfl_err_q, ovfl_err_d;
  logic [1:0]      ovfl_thr_q, ovfl_thr_d;

  logic [3:0] dec;
  logic [3:0] inc;
  logic [3:0] ovf;
  logic [3:0] eligible;

  // Occupancy and overflow update.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    ovfl_err_d = ovfl_err_q;
    ovfl_thr_d = ovfl_thr_q;
    for (int t = 0; t < 4; t++) begin
      dec[t] = pcx_ack && (state_q == REQ) && (pcx_thr_q == 2'(t)) &&
               (cnt_q[t] != '0);
      // A full buffer can still accept a store in the cycle it drains one.
      inc[t] = st_enq[t] && ((cnt_q[t] < FULL) || dec[t]);
      ovf[t] = st_enq[t] && (cnt_q[t] == FULL) && !dec[t] && !thr_flush[t];
      if (thr_flush[t])
        cnt_d[t] = '0;
      else if (inc[t] && !dec[t])
        cnt_d[t] = cnt_q[t] + 1'b1;
      else if (dec[t] && !inc[t])
        cnt_d[t] = cnt_q[t] - 1'b1;
      else
        cnt_d[t] = cnt_q[t];
    end
    // Descending scan so the lowest overflowing thread is the one captured.
    if (!ovfl_err_q) begin
      for (int t = 3; t >= 0; t--) begin
        if (ovf[t]) begin
          ovfl_err_d = 1'b1;
          ovfl_thr_d = 2'(t);
        end
      end
    end
  end

  // Drain FSM next-state: round-robin grant searched from ptr+1.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pcx_thr_d = pcx_thr_q;
    for (int t = 0; t < 4; t++)
      eligible[t] = (cnt_q[t] != '0) && !thr_flush[t];
    unique case (state_q)
      IDLE: begin
        if (drain_en && (eligible != 4'b0000)) begin
          // Scan from the farthest candidate back so the nearest one wins.
          for (int k = 4; k >= 1; k--) begin
            if (eligible[ptr_q + 2'(k)])
              pcx_thr_d = ptr_q + 2'(k);
          end
          state_d = REQ;
        end
      end
      REQ: begin
        // The request is held until ack regardless of drain_en or flush.
        if (pcx_ack) begin
          ptr_d   = pcx_thr_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd3;
      pcx_thr_q  <= 2'd0;
      ovfl_err_q <= 1'b0;
      ovfl_thr_q <= 2'd0;
      for (int t = 0; t < 4; t++) cnt_q[t] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pcx_thr_q  <= pcx_thr_d;
      ovfl_err_q <= ovfl_err_d;
      ovfl_thr_q <= ovfl_thr_d;
      for (int t = 0; t < 4; t++) cnt_q[t] <= cnt_d[t];
    end
  end

  assign pcx_req  = (state_q == REQ);
  assign pcx_thr  = pcx_thr_q;
  assign ovfl_err = ovfl_err_q;
  assign ovfl_thr = ovfl_thr_q;
  assign stbcnt0  = cnt_q[0];
  assign stbcnt1  = cnt_q[1];
  assign stbcnt2  = cnt_q[2];
  assign stbcnt3  = cnt_q[3];
  always_comb begin
    for (int t = 0; t < 4; t++) stall[t] = (cnt_q[t] == FULL);
  end

endmodule

// File: tb/tb_stb_drain_arb.sv
// -----------------------------------------------------------------------------
// tb_stb_drain_arb
// Self-checking bench for stb_drain_arb: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of per-thread counts and the round-robin drain queue.
// -----------------------------------------------------------------------------
module tb_stb_drain_arb;
  localparam int DEPTH = 8;
  localparam int CNTW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      st_enq;
  logic [3:0]      thr_flush;
  logic            drain_en;
  logic            pcx_ack;
  logic            pcx_req;
  logic [1:0]      pcx_thr;
  logic [3:0]      stall;
  logic [CNTW-1:0] stbcnt0, stbcnt1, stbcnt2, stbcnt3;
  logic            ovfl_err;
  logic [1:0]      ovfl_thr;

  stb_drain_arb #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .st_enq(st_enq), .thr_flush(thr_flush),
    .drain_en(drain_en), .pcx_ack(pcx_ack), .pcx_req(pcx_req),
    .pcx_thr(pcx_thr), .stall(stall), .stbcnt0(stbcnt0), .stbcnt1(stbcnt1),
    .stbcnt2(stbcnt2), .stbcnt3(stbcnt3), .ovfl_err(ovfl_err),
    .ovfl_thr(ovfl_thr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt [4];
  bit m_busy;
  int m_thr;
  int m_ptr;
  bit m_err;
  int m_ethr;

  always @(posedge clk) begin
    int  n [4];
    bit  d;
    int  g;
    if (rst) begin
      foreach (m_cnt[t]) m_cnt[t] = 0;
      m_busy = 0; m_thr = 0; m_ptr = 3; m_err = 0; m_ethr = 0;
    end else begin
      for (int t = 0; t < 4; t++) begin
        d = m_busy && pcx_ack && (m_thr == t) && (m_cnt[t] > 0);
        n[t] = m_cnt[t];
        if (thr_flush[t]) n[t] = 0;
        else begin
          if (d) n[t] = n[t] - 1;
          if (st_enq[t]) begin
            if (m_cnt[t] < DEPTH || d) n[t] = n[t] + 1;
            else if (!m_err) begin
              m_err = 1; m_ethr = t;
            end
          end
        end
      end
      if (m_busy) begin
        if (pcx_ack) begin
          m_busy = 0; m_ptr = m_thr;
        end
      end else if (drain_en) begin
        g = -1;
        for (int k = 1; k <= 4; k++)
          if (g < 0 && m_cnt[(m_ptr + k) % 4] > 0 && !thr_flush[(m_ptr + k) % 4])
            g = (m_ptr + k) % 4;
        if (g >= 0) begin
          m_busy = 1; m_thr = g;
        end
      end
      foreach (m_cnt[t]) m_cnt[t] = n[t];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_pcx_req", pcx_req, m_busy);
      if (m_busy) check("m_pcx_thr", pcx_thr, m_thr);
      check("m_cnt0", stbcnt0, m_cnt[0]);
      check("m_cnt1", stbcnt1, m_cnt[1]);
      check("m_cnt2", stbcnt2, m_cnt[2]);
      check("m_cnt3", stbcnt3, m_cnt[3]);
      check("m_stall", stall, {m_cnt[3] == DEPTH, m_cnt[2] == DEPTH,
                               m_cnt[1] == DEPTH, m_cnt[0] == DEPTH});
      check("m_ovfl_err", ovfl_err, m_err);
      check("m_ovfl_thr", ovfl_thr, m_ethr);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    st_enq = 4'b0; thr_flush = 4'b0; drain_en = 1'b0; pcx_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int grants [$];
    rst = 1'b1;
    idle_inputs();
    tick();
    chk_en = 1'b1;
    do_reset();

    // Reset values
    check("rst_req", pcx_req, 0);
    check("rst_thr", pcx_thr, 0);
    check("rst_stall", stall, 0);
    check("rst_cnt0", stbcnt0, 0);
    check("rst_err", ovfl_err, 0);
    check("rst_ethr", ovfl_thr, 0);

    // Single enqueue latency
    drain_en = 1; pcx_ack = 1; st_enq = 4'b0001;
    tick();
    st_enq = 4'b0;
    check("lat_cnt0_c1", stbcnt0, 1);
    check("lat_req_c1", pcx_req, 0);
    tick();
    check("lat_req_c2", pcx_req, 1);
    check("lat_thr_c2", pcx_thr, 0);
    tick();
    check("lat_cnt0_c3", stbcnt0, 0);
    check("lat_req_c3", pcx_req, 0);

    // Fill thread 2, overflow, then a second overflow on thread 1
    do_reset();
    st_enq = 4'b0100;
    repeat (8) tick();
    st_enq = 4'b0;
    check("fill_cnt2", stbcnt2, 8);
    check("fill_stall", stall, 4'b0100);
    check("fill_err", ovfl_err, 0);
    st_enq = 4'b0100;
    tick();
    check("ovf_err", ovfl_err, 1);
    check("ovf_thr", ovfl_thr, 2);
    check("ovf_cnt2", stbcnt2, 8);
    st_enq = 4'b0010;
    repeat (9) tick();
    st_enq = 4'b0;
    check("ovf2_cnt1", stbcnt1, 8);
    check("ovf2_thr", ovfl_thr, 2);

    // Enqueue at full in the same cycle as the drain ack
    do_reset();
    st_enq = 4'b0100;
    repeat (8) tick();
    st_enq = 4'b0; drain_en = 1;
    tick();
    check("fa_req", pcx_req, 1);
    check("fa_thr", pcx_thr, 2);
    drain_en = 0; st_enq = 4'b0100; pcx_ack = 1;
    tick();
    st_enq = 4'b0; pcx_ack = 0;
    check("fa_cnt2", stbcnt2, 8);
    check("fa_err", ovfl_err, 0);
    check("fa_req_off", pcx_req, 0);

    // Round robin over four threads at count 2
    do_reset();
    st_enq = 4'b1111;
    repeat (2) tick();
    st_enq = 4'b0; drain_en = 1; pcx_ack = 1;
    repeat (16) begin
      tick();
      if (pcx_req) grants.push_back(pcx_thr);
    end
    check("rr_ngrants", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      check($sformatf("rr_grant%0d", i), grants[i], i % 4);
    check("rr_cnt_sum", stbcnt0 + stbcnt1 + stbcnt2 + stbcnt3, 0);
    repeat (3) tick();
    check("rr_req_quiet", pcx_req, 0);

    // Flush during an outstanding request
    do_reset();
    st_enq = 4'b0010;
    repeat (3) tick();
    st_enq = 4'b0; drain_en = 1;
    tick();
    check("fl_req", pcx_req, 1);
    check("fl_thr", pcx_thr, 1);
    drain_en = 0; thr_flush = 4'b0010;
    tick();
    thr_flush = 4'b0;
    check("fl_cnt1", stbcnt1, 0);
    check("fl_req_hold", pcx_req, 1);
    check("fl_thr_hold", pcx_thr, 1);
    tick();
    check("fl_req_hold2", pcx_req, 1);
    pcx_ack = 1;
    tick();
    pcx_ack = 0; drain_en = 1;
    check("fl_req_done", pcx_req, 0);
    check("fl_cnt1_done", stbcnt1, 0);
    repeat (2) tick();
    check("fl_no_req", pcx_req, 0);

    // Reset while a request is outstanding; subsequent ack ignored
    do_reset();
    drain_en = 1; st_enq = 4'b0001;
    tick();
    st_enq = 4'b0;
    tick();
    check("rq_req", pcx_req, 1);
    rst = 1;
    tick();
    rst = 0; pcx_ack = 1;
    check("rq_rst_req", pcx_req, 0);
    check("rq_rst_cnt0", stbcnt0, 0);
    tick();
    pcx_ack = 0;
    check("rq_ack_req", pcx_req, 0);
    check("rq_ack_cnt0", stbcnt0, 0);
    check("rq_ack_err", ovfl_err, 0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      rst       = ($urandom_range(0, 599) == 0);
      st_enq    = 4'($urandom) & 4'($urandom);
      thr_flush = 4'b0;
      for (int t = 0; t < 4; t++)
        if ($urandom_range(0, 39) == 0) thr_flush[t] = 1'b1;
      drain_en  = ($urandom_range(0, 3) != 0);
      pcx_ack   = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    #1;
    idle_inputs();
    rst = 0;
    tick();
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
